// File: rtl/inst_encoder.sv
// RV32I instruction-word encoder with a 2-entry output FIFO and legal/illegal counters.
// Optional immediate range checking is enabled by defining ENC_IMM_CHECK_EN.
package inst_pkg;
    localparam int INST_NUM_WIDTH = 6;
    localparam int ISA_WIDTH      = 32;

    localparam logic [INST_NUM_WIDTH-1:0] INST_INV    = 6'd0;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BEQ    = 6'd1;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BNE    = 6'd2;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BLT    = 6'd3;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BGE    = 6'd4;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BLTU   = 6'd5;
    localparam logic [INST_NUM_WIDTH-1:0] INST_BGEU   = 6'd6;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LB     = 6'd7;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LH     = 6'd8;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LW     = 6'd9;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LBU    = 6'd10;
    localparam logic [INST_NUM_WIDTH-1:0] INST_LHU    = 6'd11;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SB     = 6'd12;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SH     = 6'd13;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SW     = 6'd14;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADDI   = 6'd15;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SLTI   = 6'd16;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SLTIU  = 6'd17;
    localparam logic [INST_NUM_WIDTH-1:0] INST_XORI   = 6'd18;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ORI    = 6'd19;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ANDI   = 6'd20;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SLLI   = 6'd21;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SRLI   = 6'd22;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SRAI   = 6'd23;
    localparam logic [INST_NUM_WIDTH-1:0] INST_ADD    = 6'd24;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SUB    = 6'd25;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SLL    = 6'd26;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SLT    = 6'd27;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SLTU   = 6'd28;
    localparam logic [INST_NUM_WIDTH-1:0] INST_IXOR   = 6'd29;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SRL    = 6'd30;
    localparam logic [INST_NUM_WIDTH-1:0] INST_SRA    = 6'd31;
    localparam logic [INST_NUM_WIDTH-1:0] INST_IOR    = 6'd32;
    localparam logic [INST_NUM_WIDTH-1:0] INST_IAND   = 6'd33;
    localparam logic [INST_NUM_WIDTH-1:0] INST_EBREAK = 6'd34;
endpackage

module inst_encoder
    import inst_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INST_NUM_WIDTH-1:0] in_inst_num,
    input  logic [4:0]                in_rd,
    input  logic [4:0]                in_rs1,
    input  logic [4:0]                in_rs2,
    input  logic [ISA_WIDTH-1:0]      in_imm,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ISA_WIDTH-1:0]      out_inst,
    output logic                      err,
    output logic [CNT_WIDTH-1:0]      enc_cnt,
    output logic [CNT_WIDTH-1:0]      err_cnt
);

    typedef enum logic [2:0] {
        FAM_NONE, FAM_B, FAM_LOAD, FAM_S, FAM_ALUI, FAM_SHIFT, FAM_R, FAM_SYS
    } fam_t;

    fam_t                 fam;
    logic [2:0]           f3;
    logic                 alt;
    logic                 imm_ok;
    logic                 legal;
    logic [ISA_WIDTH-1:0] word_p0;

    always_comb begin
        fam = FAM_NONE;
        f3  = 3'b000;
        alt = 1'b0;
        case (in_inst_num)
            INST_BEQ:    begin fam = FAM_B;     f3 = 3'b000; end
            INST_BNE:    begin fam = FAM_B;     f3 = 3'b001; end
            INST_BLT:    begin fam = FAM_B;     f3 = 3'b100; end
            INST_BGE:    begin fam = FAM_B;     f3 = 3'b101; end
            INST_BLTU:   begin fam = FAM_B;     f3 = 3'b110; end
            INST_BGEU:   begin fam = FAM_B;     f3 = 3'b111; end
            INST_LB:     begin fam = FAM_LOAD;  f3 = 3'b000; end
            INST_LH:     begin fam = FAM_LOAD;  f3 = 3'b001; end
            INST_LW:     begin fam = FAM_LOAD;  f3 = 3'b010; end
            INST_LBU:    begin fam = FAM_LOAD;  f3 = 3'b100; end
            INST_LHU:    begin fam = FAM_LOAD;  f3 = 3'b101; end
            INST_SB:     begin fam = FAM_S;     f3 = 3'b000; end
            INST_SH:     begin fam = FAM_S;     f3 = 3'b001; end
            INST_SW:     begin fam = FAM_S;     f3 = 3'b010; end
            INST_ADDI:   begin fam = FAM_ALUI;  f3 = 3'b000; end
            INST_SLTI:   begin fam = FAM_ALUI;  f3 = 3'b010; end
            INST_SLTIU:  begin fam = FAM_ALUI;  f3 = 3'b011; end
            INST_XORI:   begin fam = FAM_ALUI;  f3 = 3'b100; end
            INST_ORI:    begin fam = FAM_ALUI;  f3 = 3'b110; end
            INST_ANDI:   begin fam = FAM_ALUI;  f3 = 3'b111; end
            INST_SLLI:   begin fam = FAM_SHIFT; f3 = 3'b001; end
            INST_SRLI:   begin fam = FAM_SHIFT; f3 = 3'b101; end
            INST_SRAI:   begin fam = FAM_SHIFT; f3 = 3'b101; alt = 1'b1; end
            INST_ADD:    begin fam = FAM_R;     f3 = 3'b000; end
            INST_SUB:    begin fam = FAM_R;     f3 = 3'b000; alt = 1'b1; end
            INST_SLL:    begin fam = FAM_R;     f3 = 3'b001; end
            INST_SLT:    begin fam = FAM_R;     f3 = 3'b010; end
            INST_SLTU:   begin fam = FAM_R;     f3 = 3'b011; end
            INST_IXOR:   begin fam = FAM_R;     f3 = 3'b100; end
            INST_SRL:    begin fam = FAM_R;     f3 = 3'b101; end
            INST_SRA:    begin fam = FAM_R;     f3 = 3'b101; alt = 1'b1; end
            INST_IOR:    begin fam = FAM_R;     f3 = 3'b110; end
            INST_IAND:   begin fam = FAM_R;     f3 = 3'b111; end
            INST_EBREAK: begin fam = FAM_SYS; end
            default:     begin fam = FAM_NONE; end
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    // Range test: upper bits must be a pure sign extension of the field.
    always_comb begin
        imm_ok = 1'b1;
        case (fam)
            FAM_B:                       imm_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
            FAM_LOAD, FAM_S, FAM_ALUI:   imm_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
            FAM_SHIFT:                   imm_ok = ~(|in_imm[31:5]);
            default:                     imm_ok = 1'b1;
        endcase
    end
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:13];
    assign imm_ok        = 1'b1;
`endif

    assign legal = (fam != FAM_NONE) && imm_ok;

    always_comb begin
        word_p0 = '0;
        case (fam)
            FAM_B:     word_p0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                                  in_imm[4:1], in_imm[11], 7'b1100011};
            FAM_LOAD:  word_p0 = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0000011};
            FAM_S:     word_p0 = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
            FAM_ALUI:  word_p0 = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
            FAM_SHIFT: word_p0 = {1'b0, alt, 5'b00000, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
            FAM_R:     word_p0 = {1'b0, alt, 5'b00000, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
            FAM_SYS:   word_p0 = 32'h0010_0073;
            default:   word_p0 = '0;
        endcase
    end

    // ---- stage boundary: handshake into FIFO and counters ----
    logic [ISA_WIDTH-1:0] mem [DEPTH];
    logic                 rptr;
    logic                 wptr;
    logic [1:0]           count;
    logic                 accept;
    logic                 push;
    logic                 pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_inst  = out_valid ? mem[rptr] : '0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= word_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr    <= 1'b0;
            wptr    <= 1'b0;
            count   <= 2'd0;
            err     <= 1'b0;
            enc_cnt <= '0;
            err_cnt <= '0;
        end else begin
            err <= accept && !legal;
            if (push) begin
                wptr    <= ~wptr;
                enc_cnt <= enc_cnt + CNT_WIDTH'(1);
            end
            if (accept && !legal) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction-word encoder for the NPC test infrastructure: the inverse of the IDU funct3/opcode decode path. It accepts a symbolic instruction number plus register and immediate operands over a valid/ready handshake and produces the corresponding 32-bit RV32I word into a 2-entry output FIFO. It feeds self-test instruction streams into IFU-side memories and gives the decoder round-trip checks, with per-stream legal/illegal counters.

## Interface
- `DEPTH`, 2: output FIFO entries; fixed at 2, other values unsupported.
- `CNT_WIDTH`, 32: width of `enc_cnt` and `err_cnt`.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted this cycle when high together with `in_valid`.
- `in_inst_num`  in  `INST_NUM_WIDTH`  instruction number from inst.vh (`beq`, `lw`, `addi`, `ebreak`, …).
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices.
- `in_imm`  in  `ISA_WIDTH`  immediate or shamt, sign-extended to 32 bits.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer takes head.
- `out_inst`  out  `ISA_WIDTH`  encoded word at FIFO head.
- `err`  out  1  one-cycle pulse: an illegal request was accepted and dropped.
- `enc_cnt`  out  `CNT_WIDTH`  legal requests encoded since reset.
- `err_cnt`  out  `CNT_WIDTH`  illegal requests dropped since reset.

## Operation
- Supported numbers: `beq bne blt bge bltu bgeu`, `lb lh lw lbu lhu`, `sb sh sw`, `addi slti sltiu xori ori andi slli srli srai`, `add sub sll slt sltu ixor srl sra ior iand`, `ebreak`. Every other value, including `inv`, is illegal.
- Format by family:
  - B: imm[12|10:5] at [31:25], imm[4:1|11] at [11:7]; opcode 1100011.
  - Load: I-type, opcode 0000011.
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7]; opcode 0100011.
  - ALU-imm: I-type, opcode 0010011.
  - Shifts: shamt = imm[4:0] at [24:20], funct7 0100000 for `srai`, else 0000000.
  - R-type: opcode 0110011, funct7 0100000 for `sub`/`sra`.
  - `ebreak`: fixed 0x00100073; operands ignored.
- funct3 values are exactly those the IDU decodes, e.g. `lbu` = 100, `sltiu` = 011, `ior` = 110.
- Fields unused by a format are ignored: rd for B/S, rs2 for I.
- Accepted legal request: encoded word pushed to FIFO, `enc_cnt` += 1.
- Accepted illegal request: nothing pushed, `err` pulses, `err_cnt` += 1.
- FIFO: 2 entries, read pointer, write pointer, 2-bit count. Pointers wrap modulo 2.
- Counters wrap to 0 after the all-ones value; no saturation.

## Timing
- Reset values: FIFO empty, so `out_valid`=0 and `out_inst`=0; `in_ready`=1 in the cycle after reset; `err`=0; both counters 0.
- A reset asserted mid-stream discards all FIFO contents in the same edge.
- `in_ready` = (count < 2), derived from registered count only. It does not depend on `out_ready`, so there is no pass-through when full.
- Latency: a request accepted at edge N is presented on `out_inst` with `out_valid`=1 from edge N+1, when the FIFO was empty.
- Simultaneous push and pop with count=1: count stays 1 and the head advances to the new word.
- Pop when empty has no effect. An illegal accept while full cannot happen because `in_ready`=0.
- `out_inst` is held stable while `out_valid`=1 and `out_ready`=0.
- `err` is registered: high for exactly the cycle after the illegal accept.

## Configuration
- `ENC_IMM_CHECK_EN` defined: an out-of-range immediate makes the request illegal. Ranges:
  - I/S/load: signed 12-bit.
  - B: signed 13-bit with imm[0]=0.
  - Shifts: imm[31:5]=0.
- `ENC_IMM_CHECK_EN` undefined: immediates are silently truncated to their field bits, B imm[0] is ignored, and only unknown instruction numbers are illegal.

## Test plan
- Reset, then `addi` rd=1 rs1=0 imm=5, `out_ready`=1 → `out_inst`=0x00500093 one cycle later; `enc_cnt`=1.
- `sw` rs1=1 rs2=2 imm=8 → 0x0020A423. `beq` rs1=1 rs2=2 imm=-4 → 0xFE208EE3.
- `sub` rd=3 rs1=1 rs2=2 → 0x402081B3. `srai` rd=5 rs1=6 imm=3 → 0x40335293. `ebreak` → 0x00100073.
- `out_ready`=0 with 3 back-to-back requests → `in_ready` falls after the 2nd accept. Release `out_ready` → words drain in order and `in_ready` returns one cycle after the first pop.
- `in_inst_num`=`inv` → no push, `err` high one cycle, `err_cnt`=1. With `ENC_IMM_CHECK_EN`, `addi` imm=4096 → illegal; without it → 0x00000093 for rd=1, rs1=0.
- Assert `rst` with 2 entries queued → next cycle `out_valid`=0, `in_ready`=1, counters 0.
